jam_perm_gen: RTL

Lexicographic permutation sequencer for the job-assignment engine. Starting from the identity assignment, it walks all N! worker-to-job assignments in strictly increasing lexicographic order. Each assignment is presented on a valid/ready stream to the downstream cost accumulator, which addresses the 8×8 cost ROM as W = worker, J = perm[worker]. The block owns the sequencing only; it never reads costs.

---
 rtl/jam_pkg.sv | 23 ++
 rtl/jam_perm_scan.sv | 41 ++++
 rtl/jam_perm_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// Shared definitions for the lexicographic permutation sequencer.
//   JAM_N / JAM_IDXW / JAM_CNTW : default worker count, job-index width, ordinal width
//   perm_state_e                : sequencer FSM states
//   perm_t                      : packed assignment, element i = job of worker i
package jam_pkg;

  localparam int unsigned JAM_N    = 8;
  localparam int unsigned JAM_IDXW = 3;
  localparam int unsigned JAM_CNTW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StEmit,
    StPivot,
    StSucc,
    StSwap,
    StRev,
    StFin
  } perm_state_e;

  typedef logic [JAM_N-1:0][JAM_IDXW-1:0] perm_t;

endpackage

// File: rtl/jam_perm_scan.sv
// Combinational scan of one assignment.
//   i_perm    : assignment, element i = job of worker i
//   i_k       : pivot position used for the successor search
//   o_pivot   : largest i in 0..N-2 with p[i] < p[i+1]
//   o_succ    : largest j > i_k with p[j] > p[i_k]
//   o_is_last : assignment is strictly descending (no pivot exists)
module jam_perm_scan
  import jam_pkg::*;
#(
  parameter int unsigned N    = JAM_N,
  parameter int unsigned IDXW = JAM_IDXW
) (
  input  logic [N-1:0][IDXW-1:0] i_perm,
  input  logic [IDXW-1:0]        i_k,
  output logic [IDXW-1:0]        o_pivot,
  output logic [IDXW-1:0]        o_succ,
  output logic                   o_is_last
);

  // Ascending loop: the last hit overwrites earlier ones, giving the largest index.
  always_comb begin
    o_pivot   = '0;
    o_is_last = 1'b1;
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (i_perm[i] < i_perm[i+1]) begin
        o_pivot   = IDXW'(i);
        o_is_last = 1'b0;
      end
    end
  end

  always_comb begin
    o_succ = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (j > int'(i_k) && i_perm[j] > i_perm[i_k]) begin
        o_succ = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/jam_perm_gen.sv
// Lexicographic permutation sequencer: walks all N! worker-to-job assignments from
// the identity upward and presents each on a valid/ready stream.
//   CLK, RST   : clock, synchronous active-high reset
//   start      : begin a sweep (only honoured while idle)
//   perm_valid : perm / perm_idx / perm_last valid
//   perm_ready : downstream accepts
//   perm       : job of worker i on bits [i*IDXW +: IDXW]
//   perm_idx   : ordinal of the presented assignment
//   perm_last  : presented assignment is the final (strictly descending) one
//   busy       : sweep in progress
//   done       : one-cycle pulse after the final transfer
module jam_perm_gen
  import jam_pkg::*;
#(
  parameter int unsigned N    = JAM_N,
  parameter int unsigned IDXW = JAM_IDXW,
  parameter int unsigned CNTW = JAM_CNTW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              perm_valid,
  input  logic              perm_ready,
  output logic [N*IDXW-1:0] perm,
  output logic [CNTW-1:0]   perm_idx,
  output logic              perm_last,
  output logic              busy,
  output logic              done
);

  typedef logic [N-1:0][IDXW-1:0] perm_n_t;

  perm_state_e     r_state, w_state_nxt;
  perm_n_t         r_perm, w_ident, w_swap, w_rev;
  logic [IDXW-1:0] r_k, r_m, w_pivot, w_succ;
  logic [CNTW-1:0] r_idx;
  logic            w_is_last;

  jam_perm_scan #(
    .N    (N),
    .IDXW (IDXW)
  ) u_scan (
    .i_perm    (r_perm),
    .i_k       (r_k),
    .o_pivot   (w_pivot),
    .o_succ    (w_succ),
    .o_is_last (w_is_last)
  );

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      w_ident[i] = IDXW'(i);
    end
  end

  always_comb begin
    w_swap      = r_perm;
    w_swap[r_k] = r_perm[r_m];
    w_swap[r_m] = r_perm[r_k];
  end

  // Suffix k+1..N-1 reversed: position i takes element N+k-i.
  always_comb begin
    w_rev = r_perm;
    for (int i = 0; i < int'(N); i++) begin
      if (i > int'(r_k)) begin
        w_rev[i] = r_perm[IDXW'(int'(N) + int'(r_k) - i)];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_nxt = StEmit;
      StEmit:  if (perm_ready) w_state_nxt = w_is_last ? StFin : StPivot;
      StPivot: w_state_nxt = StSucc;
      StSucc:  w_state_nxt = StSwap;
      StSwap:  w_state_nxt = StRev;
      StRev:   w_state_nxt = StEmit;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM: outputs (decoded from registered state and data only)
  always_comb begin
    perm       = r_perm;
    perm_idx   = r_idx;
    perm_valid = (r_state == StEmit);
    perm_last  = (r_state == StEmit) && w_is_last;
    busy       = (r_state != StIdle);
    done       = (r_state == StFin);
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perm <= '0;
      r_idx  <= '0;
      r_k    <= '0;
      r_m    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_perm <= w_ident;
            r_idx  <= '0;
          end
        end
        StPivot: r_k <= w_pivot;
        StSucc:  r_m <= w_succ;
        StSwap:  r_perm <= w_swap;
        StRev: begin
          r_perm <= w_rev;
          r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
